// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame sequencer: strips preamble/SFD, parses MAC header and EtherType,
// forwards payload with SOF and keeps frame/drop statistics. Optional: RX_MAC_FILTER_EN.
module eth_rx_frame_ctrl #(
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned MAX_PAYLOAD = 1504,
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [7:0]  rxDataIn,
    input  logic        rxDataValidIn,
    output logic [7:0]  payloadDataOut,
    output logic        payloadValidOut,
    output logic        payloadSofOut,
    output logic        frameDoneOut,
    output logic        frameErrOut,
    output logic [15:0] etherTypeOut,
    output logic [10:0] payloadLenOut,
    output logic [15:0] frameCntOut,
    output logic [15:0] dropCntOut
);

    if (GAP_CYCLES < 3 || GAP_CYCLES > 255 || LOCAL_MAC[40]) begin : g_bad_param
        $error("eth_rx_frame_ctrl: GAP_CYCLES out of 3..255 or LOCAL_MAC is a group address");
    end

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DST_MAC, SRC_MAC, ETYPE, PAYLOAD, DROP
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [2:0]  pre_cnt;
    logic [2:0]  hdr_cnt;
    logic [7:0]  etype_hi;
    logic [10:0] pay_cnt;
    logic        ovf_drop;
    logic        gap_expired;
`ifdef RX_MAC_FILTER_EN
    // Only the first five octets are stored; the sixth is compared as it arrives.
    logic [39:0] dst_mac;
`endif

    assign gap_expired = (state != IDLE) && !rxDataValidIn && (gap_cnt == GAP_LAST);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            pre_cnt         <= '0;
            hdr_cnt         <= '0;
            etype_hi        <= '0;
            pay_cnt         <= '0;
            ovf_drop        <= 1'b0;
            payloadDataOut  <= '0;
            payloadValidOut <= 1'b0;
            payloadSofOut   <= 1'b0;
            frameDoneOut    <= 1'b0;
            frameErrOut     <= 1'b0;
            etherTypeOut    <= '0;
            payloadLenOut   <= '0;
            frameCntOut     <= '0;
            dropCntOut      <= '0;
`ifdef RX_MAC_FILTER_EN
            dst_mac         <= '0;
`endif
        end else begin
            payloadValidOut <= 1'b0;
            payloadSofOut   <= 1'b0;
            frameDoneOut    <= 1'b0;
            frameErrOut     <= 1'b0;

            if (state == IDLE || rxDataValidIn || gap_expired) gap_cnt <= '0;
            else                                              gap_cnt <= gap_cnt + 8'd1;

            if (gap_expired) begin
                state <= IDLE;
                unique case (state)
                    PAYLOAD: begin
                        if (pay_cnt >= MIN_LEN) begin
                            frameDoneOut  <= 1'b1;
                            payloadLenOut <= pay_cnt;
                            frameCntOut   <= sat_inc(frameCntOut);
                        end else begin
                            frameErrOut <= 1'b1;
                            dropCntOut  <= sat_inc(dropCntOut);
                        end
                    end
                    PREAMBLE, DST_MAC, SRC_MAC, ETYPE: begin
                        frameErrOut <= 1'b1;
                        dropCntOut  <= sat_inc(dropCntOut);
                    end
                    // An overflow was already counted when it happened.
                    DROP: if (!ovf_drop) dropCntOut <= sat_inc(dropCntOut);
                    default: ;
                endcase
            end else if (rxDataValidIn) begin
                unique case (state)
                    IDLE: begin
                        ovf_drop <= 1'b0;
                        if (rxDataIn == 8'h55) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                    PREAMBLE: begin
                        if (rxDataIn == 8'h55) begin
                            if (pre_cnt == 3'd7) state <= DROP;
                            else                 pre_cnt <= pre_cnt + 3'd1;
                        end else if (rxDataIn == 8'hD5) begin
                            state   <= DST_MAC;
                            hdr_cnt <= '0;
                        end else begin
                            state <= DROP;
                        end
                    end
                    DST_MAC: begin
`ifdef RX_MAC_FILTER_EN
                        dst_mac <= {dst_mac[31:0], rxDataIn};
`endif
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == 3'd5) begin
                            hdr_cnt <= '0;
`ifdef RX_MAC_FILTER_EN
                            if ({dst_mac, rxDataIn} == LOCAL_MAC || {dst_mac, rxDataIn} == '1)
                                state <= SRC_MAC;
                            else
                                state <= DROP;
`else
                            state <= SRC_MAC;
`endif
                        end
                    end
                    SRC_MAC: begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == 3'd5) begin
                            hdr_cnt <= '0;
                            state   <= ETYPE;
                        end
                    end
                    ETYPE: begin
                        if (hdr_cnt == 3'd0) begin
                            etype_hi <= rxDataIn;
                            hdr_cnt  <= 3'd1;
                        end else begin
                            etherTypeOut <= {etype_hi, rxDataIn};
                            pay_cnt      <= '0;
                            state        <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (pay_cnt == MAX_LEN) begin
                            frameErrOut <= 1'b1;
                            dropCntOut  <= sat_inc(dropCntOut);
                            ovf_drop    <= 1'b1;
                            state       <= DROP;
                        end else begin
                            payloadDataOut  <= rxDataIn;
                            payloadValidOut <= 1'b1;
                            payloadSofOut   <= (pay_cnt == '0);
                            pay_cnt         <= pay_cnt + 11'd1;
                        end
                    end
                    DROP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
- Receive-side frame sequencer in the 250 MHz domain, fed directly by the slow_fast_cdc read port: rdDataOut drives rxDataIn, rdDataValidOut drives rxDataValidIn.
- Delineates Ethernet frames in the byte stream and strips the preamble/SFD.
- Parses the destination MAC, source MAC and EtherType, then forwards payload bytes with start-of-frame and end-of-frame markers to the book-building logic.
- Keeps frame and drop statistics.

Parameters:
- GAP_CYCLES, 8: consecutive clkIn cycles with no valid byte that mark end of frame; legal range 3..255.
- MAX_PAYLOAD, 1504: maximum payload bytes including FCS; exceeding it is an error.
- MIN_PAYLOAD, 46: minimum payload bytes for a good frame.
- LOCAL_MAC, 48'h02_00_00_00_00_01: station address; used only with RX_MAC_FILTER_EN.

Ports:
- clkIn  input  1  250 MHz clock
- rstIn  input  1  synchronous, active-high reset
- rxDataIn  input  8  byte from the CDC FIFO
- rxDataValidIn  input  1  byte qualifier; asserts at most once per 2 cycles during a frame
- payloadDataOut  output  8  payload byte
- payloadValidOut  output  1  payloadDataOut valid
- payloadSofOut  output  1  high with the first payload byte
- frameDoneOut  output  1  1-cycle pulse: good frame ended
- frameErrOut  output  1  1-cycle pulse: frame aborted or truncated
- etherTypeOut  output  16  EtherType of the current/last frame, latched
- payloadLenOut  output  11  payload byte count, latched at frameDoneOut
- frameCntOut  output  16  good frames, saturating
- dropCntOut  output  16  dropped/errored frames, saturating

Behaviour:
- Reset: all outputs 0, FSM in IDLE, gap counter 0. A reset mid-frame discards the frame with no pulses and no counter updates.
- States: IDLE, PREAMBLE, DST_MAC, SRC_MAC, ETYPE, PAYLOAD, DROP.
- IDLE:
  - byte 0x55 -> PREAMBLE, preamble count = 1.
  - any other byte -> DROP.
- PREAMBLE:
  - 0x55 increments the count; an 8th consecutive 0x55 -> DROP.
  - 0xD5 -> DST_MAC.
  - any other byte -> DROP.
- DST_MAC: consume 6 bytes, shifting them into the dst register MSB-first, then -> SRC_MAC.
- SRC_MAC: consume 6 bytes, then -> ETYPE.
- ETYPE: 2 bytes, big-endian. etherTypeOut updates on the cycle after the 2nd byte; next state PAYLOAD.
- PAYLOAD:
  - Each valid byte appears on payloadDataOut/payloadValidOut exactly 1 cycle later (registered).
  - payloadSofOut is high on the first payload byte only.
  - The byte counter increments per byte; the FCS is forwarded as payload.
- Overflow: on the payload byte that would make the count MAX_PAYLOAD+1:
  - the byte is not forwarded;
  - frameErrOut pulses 1 cycle later;
  - dropCnt increments;
  - FSM -> DROP.
- DROP: consume bytes silently until a gap.
- Gap counter:
  - Runs in every state except IDLE; clears on any cycle with rxDataValidIn=1.
  - A valid byte arriving in the same cycle the counter would reach GAP_CYCLES takes priority: no end of frame.
- End of frame, when the gap counter reaches GAP_CYCLES. Checks in priority order, one pulse at most:
  - PAYLOAD with count >= MIN_PAYLOAD: frameDoneOut pulse; payloadLenOut = count; frameCnt++.
  - PAYLOAD with count < MIN_PAYLOAD, or ending in PREAMBLE..ETYPE: frameErrOut pulse; dropCnt++.
  - DROP entered by overflow: no further pulse and no further count.
  - DROP otherwise: dropCnt++ only, no pulse.
  - All cases -> IDLE. The pulse is issued in the same cycle as the IDLE transition.
- Counters saturate at 16'hFFFF. payloadLenOut and etherTypeOut hold until their next update.
- Back-to-back frames are legal whenever separated by >= GAP_CYCLES idle cycles.

Optional Feature:
- Macro: RX_MAC_FILTER_EN.
- Defined:
  - At the end of DST_MAC, the address is compared against LOCAL_MAC and FF:FF:FF:FF:FF:FF.
  - Mismatch -> DROP; no payload is forwarded and dropCnt increments at end of frame.
  - etherTypeOut is not updated for filtered frames.
- Undefined: no comparison is made, all destinations are accepted, and LOCAL_MAC is unused.

Test Plan:
- Good frame, 1 byte per 2 cycles: 7x55, D5, dst 02:00:00:00:00:01, src any, type 0x0800, 60 payload bytes 0x00..0x3B, then 10 idle cycles -> payload 0x00..0x3B in order, each 1 cycle after input, SOF on 0x00, frameDoneOut once, payloadLenOut=60, etherTypeOut=0x0800, frameCntOut=1.
- Bad preamble: 55 55 AA … then gap -> no payload, no pulse, dropCntOut=1. Separately, 9x55 then D5 -> dropped, dropCntOut increments.
- Runt and overflow: a 20-byte payload -> frameErrOut, dropCntOut+1. A 1505-byte payload -> exactly 1504 bytes forwarded, frameErrOut once, dropCntOut+1 once.
- Gap boundary: insert a GAP_CYCLES-1 idle stretch mid-payload -> frame continues. A valid byte on the exact gap-expiry cycle -> frame continues.
- Reset in PAYLOAD after 30 bytes, then a fresh good frame -> no pulses for the aborted frame, counters 0 then frameCntOut=1.
- With RX_MAC_FILTER_EN: dst 02:00:00:00:00:02 -> dropped, dropCntOut=1. dst FF:FF:FF:FF:FF:FF -> accepted. Without the macro, the 02:..:02 frame is accepted.
